// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use scoreboard, structural limit of three
// outstanding loads, memory-wait and branch-flush sequencing. Optional
// statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_ctrl (
  input  logic        CLK,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_load,
  input  logic [4:0]  id_rd,
  input  logic        ld_done,
  input  logic [4:0]  ld_done_rd,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic        stall,
  output logic        bubble,
  output logic        flush,
  output logic        issue,
  output logic [31:0] pending,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_HAZARD  = 2'd1;
  localparam logic [1:0] ST_MEMWAIT = 2'd2;
  localparam logic [1:0] ST_FLUSH   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [1:0]  count_q, count_d;

  logic rs1_hit, rs2_hit, raw, struct_haz, load_set;
  logic [31:0] set_mask, clr_mask;

  // A register being written back this cycle is bypassed, so it never blocks.
  always_comb begin
    rs1_hit = id_use_rs1 && (id_rs1 != 5'd0) && pending_q[id_rs1] &&
              !(ld_done && (ld_done_rd == id_rs1));
    rs2_hit = id_use_rs2 && (id_rs2 != 5'd0) && pending_q[id_rs2] &&
              !(ld_done && (ld_done_rd == id_rs2));
    raw        = id_valid && (rs1_hit || rs2_hit);
    struct_haz = id_valid && id_load && (count_q == 2'd3);
    flush      = br_taken || (state_q == ST_FLUSH);
    stall      = !flush && (mem_busy || raw || struct_haz);
    bubble     = stall || flush;
    issue      = id_valid && !stall && !flush;
  end

  always_comb begin
    load_set  = issue && id_load && (id_rd != 5'd0);
    set_mask  = load_set ? (32'd1 << id_rd) : 32'd0;
    clr_mask  = ld_done ? (32'd1 << ld_done_rd) : 32'd0;
    pending_d = ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
    count_d   = count_q;
    if (load_set && ld_done)
      count_d = count_q;
    else if (load_set)
      count_d = count_q + 2'd1;
    else if (ld_done && (count_q != 2'd0))
      count_d = count_q - 2'd1;
  end

  always_comb begin
    state_d = ST_RUN;
    if (br_taken)
      state_d = ST_FLUSH;
    else if (mem_busy)
      state_d = ST_MEMWAIT;
    else if (raw || struct_haz)
      state_d = ST_HAZARD;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      pending_q <= 32'd0;
      count_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending = pending_q;
  assign state   = state_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  // Stall counter wraps; flush counter saturates.
  always_comb begin
    stall_cycles_d = stall ? stall_cycles_q + 32'd1 : stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (br_taken && (flush_count_q != 16'hFFFF))
      flush_count_d = flush_count_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl; expected values go through a tagged
// scoreboard queue. Statistics expectations follow HAZARD_STATS_EN.
module tb_hazard_ctrl;

  logic        CLK;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic        id_load;
  logic [4:0]  id_rd;
  logic        ld_done;
  logic [4:0]  ld_done_rd;
  logic        br_taken;
  logic        mem_busy;
  logic        stall, bubble, flush, issue;
  logic [31:0] pending;
  logic [1:0]  state;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl dut (
    .CLK          (CLK),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_load      (id_load),
    .id_rd        (id_rd),
    .ld_done      (ld_done),
    .ld_done_rd   (ld_done_rd),
    .br_taken     (br_taken),
    .mem_busy     (mem_busy),
    .stall        (stall),
    .bubble       (bubble),
    .flush        (flush),
    .issue        (issue),
    .pending      (pending),
    .state        (state),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] observe(input string tag);
    case (tag)
      "stall":        return {31'd0, stall};
      "bubble":       return {31'd0, bubble};
      "flush":        return {31'd0, flush};
      "issue":        return {31'd0, issue};
      "state":        return {30'd0, state};
      "pending":      return pending;
      "stall_cycles": return stall_cycles;
      "flush_count":  return {16'd0, flush_count};
      default:        return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic pushExp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic expectCtl(input logic s, input logic b, input logic f,
                           input logic i, input logic [1:0] st);
    pushExp("stall", {31'd0, s});
    pushExp("bubble", {31'd0, b});
    pushExp("flush", {31'd0, f});
    pushExp("issue", {31'd0, i});
    pushExp("state", {30'd0, st});
  endtask

  // Drains the scoreboard against the DUT outputs as they stand now.
  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.tag);
      checks++;
      assert (obs === e.exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h at %0t", e.tag, obs, e.exp, $time);
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 time units later.
  task automatic applyStimulus(input logic vld, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic ld,
                               input logic [4:0] rd, input logic ldd,
                               input logic [4:0] ldd_rd, input logic br,
                               input logic mb);
    @(negedge CLK);
    id_valid   = vld;
    id_rs1     = rs1;
    id_rs2     = rs2;
    id_use_rs1 = u1;
    id_use_rs2 = u2;
    id_load    = ld;
    id_rd      = rd;
    ld_done    = ldd;
    ld_done_rd = ldd_rd;
    br_taken   = br;
    mem_busy   = mb;
    #2;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic loadOp(input logic [4:0] rd, input logic ldd, input logic [4:0] ldd_rd);
    applyStimulus(1, 0, 0, 0, 0, 1, rd, ldd, ldd_rd, 0, 0);
  endtask

  // add x6, x5, x0
  task automatic depOp(input logic ldd, input logic [4:0] ldd_rd,
                       input logic br, input logic mb);
    applyStimulus(1, 5, 0, 1, 1, 0, 6, ldd, ldd_rd, br, mb);
  endtask

  task automatic doReset();
    idle();
    reset = 1'b0;
    #1;
    pushExp("pending", 32'd0);
    pushExp("stall_cycles", 32'd0);
    pushExp("flush_count", 32'd0);
    expectCtl(0, 0, 0, 0, 2'd0);
    checkOutput();
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    id_valid   = 1'b0;
    id_rs1     = 5'd0;
    id_rs2     = 5'd0;
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    id_load    = 1'b0;
    id_rd      = 5'd0;
    ld_done    = 1'b0;
    ld_done_rd = 5'd0;
    br_taken   = 1'b0;
    mem_busy   = 1'b0;

    // Load-use stall released by write-back of x5
    doReset();
    loadOp(5, 0, 0);
    expectCtl(0, 0, 0, 1, 2'd0); checkOutput();
    depOp(0, 0, 0, 0);
    expectCtl(1, 1, 0, 0, 2'd0); pushExp("pending", 32'h20); checkOutput();
    depOp(0, 0, 0, 0);
    expectCtl(1, 1, 0, 0, 2'd1); checkOutput();
    depOp(1, 5, 0, 0);
    expectCtl(0, 0, 0, 1, 2'd1); checkOutput();
    idle();
    expectCtl(0, 0, 0, 0, 2'd0); pushExp("pending", 32'd0); checkOutput();

    // Write-back in the dependent's first cycle bypasses the hazard
    doReset();
    loadOp(5, 0, 0);
    expectCtl(0, 0, 0, 1, 2'd0); checkOutput();
    depOp(1, 5, 0, 0);
    expectCtl(0, 0, 0, 1, 2'd0); checkOutput();
    idle();
    expectCtl(0, 0, 0, 0, 2'd0); pushExp("pending", 32'd0); checkOutput();

    // Taken branch overrides a RAW stall and flushes for two cycles
    doReset();
    loadOp(5, 0, 0);
    depOp(0, 0, 0, 0);
    expectCtl(1, 1, 0, 0, 2'd0); checkOutput();
    depOp(0, 0, 1, 0);
    expectCtl(0, 1, 1, 0, 2'd1); checkOutput();
    idle();
    expectCtl(0, 1, 1, 0, 2'd3); checkOutput();
    idle();
    expectCtl(0, 0, 0, 0, 2'd0);
    pushExp("flush_count", STATS ? 32'd1 : 32'd0);
    pushExp("pending", 32'h20);
    checkOutput();

    // Structural limit: fourth outstanding load waits for a write-back
    doReset();
    loadOp(1, 0, 0);
    expectCtl(0, 0, 0, 1, 2'd0); checkOutput();
    loadOp(2, 0, 0);
    expectCtl(0, 0, 0, 1, 2'd0); checkOutput();
    loadOp(3, 0, 0);
    expectCtl(0, 0, 0, 1, 2'd0); checkOutput();
    loadOp(4, 0, 0);
    expectCtl(1, 1, 0, 0, 2'd0); pushExp("pending", 32'h0000000E); checkOutput();
    loadOp(4, 1, 1);
    expectCtl(1, 1, 0, 0, 2'd1); checkOutput();
    loadOp(4, 0, 0);
    expectCtl(0, 0, 0, 1, 2'd1); pushExp("pending", 32'h0000000C); checkOutput();
    idle();
    expectCtl(0, 0, 0, 0, 2'd0); pushExp("pending", 32'h0000001C); checkOutput();

    // Memory busy for four cycles on top of a RAW hazard
    doReset();
    loadOp(5, 0, 0);
    depOp(0, 0, 0, 1);
    expectCtl(1, 1, 0, 0, 2'd0); checkOutput();
    for (int i = 0; i < 3; i++) begin
      depOp(0, 0, 0, 1);
      expectCtl(1, 1, 0, 0, 2'd2); checkOutput();
    end
    depOp(1, 5, 0, 0);
    expectCtl(0, 0, 0, 1, 2'd2); checkOutput();
    idle();
    expectCtl(0, 0, 0, 0, 2'd0);
    pushExp("stall_cycles", STATS ? 32'd4 : 32'd0);
    checkOutput();

    // Asynchronous reset in the middle of a hazard, before any clock edge
    doReset();
    loadOp(5, 0, 0);
    depOp(0, 0, 0, 0);
    depOp(0, 0, 0, 0);
    expectCtl(1, 1, 0, 0, 2'd1); pushExp("pending", 32'h20); checkOutput();
    reset = 1'b0;
    #1;
    expectCtl(0, 0, 0, 1, 2'd0); pushExp("pending", 32'd0); checkOutput();
    reset = 1'b1;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
